kws_macc_sequencer: RTL and testbench
=====================================

// Module: kws_macc_sequencer
// PURPOSE
//  Multi-cycle sequencer for the 4-lane int8 SIMD multiply-accumulate datapath used by KWS conv kernels.
//  Owns local filter/input word buffers, input_offset and the 32-bit accumulator; one CFU "run" command
//  streams LEN packed words through the MAC datapath (one word/cycle) instead of one CPU op per word.
//  Sits directly on the CPU CFU bus; replaces per-word CPU issue with a buffered burst.
// PARAMETERS
//  DEPTH   16  words per buffer (filter and input each); power of two
//  ADDR_W  4   log2(DEPTH); buffer index width
// PORTS
//  clk                      in   1   single clock; all state updates on posedge
//  reset                    in   1   asynchronous, active-high; clears all state
//  cmd_valid                in   1   command offered by CPU
//  cmd_ready                out  1   command accepted when cmd_valid & cmd_ready
//  cmd_payload_function_id  in   3   opcode (see BEHAVIOUR)
//  cmd_payload_inputs_0     in   32  operand A
//  cmd_payload_inputs_1     in   32  operand B
//  rsp_valid                out  1   response held valid until rsp_ready
//  rsp_ready                in   1   CPU accepts response
//  rsp_payload_response_ok  out  1   constant 1
//  rsp_payload_outputs_0    out  32  registered result
// BEHAVIOUR
//  Reset (async): state=IDLE, acc=0, input_offset=0, rsp_valid=0, outputs_0=0, run idx/count=0; buffers not cleared.
//  cmd_ready = (state==IDLE); rsp_valid = (state==RESP). No new command accepted while RUN or RESP.
//  Opcodes (in1=inputs_0, in2=inputs_1), result latched into outputs_0 on entering RESP:
//   0 SET_OFF  input_offset <= in1[8:0] (signed 9b); result 0
//   1 SET_ACC  acc <= in1; result in1
//   2 WR_FILT  filt_buf[in1[ADDR_W-1:0]] <= in2; result 0
//   3 WR_IN    in_buf[in1[ADDR_W-1:0]] <= in2; result 0
//   4 RUN      idx <= in1[ADDR_W-1:0], cnt <= in2[15:0]; go RUN (or RESP directly if cnt==0); result = final acc
//   5 RD_ACC   result acc
//   6 RD_PERF  result perf counter (0 when feature compiled out)
//   7 reserved: no state change; result 0
//  FSM: IDLE -(accept, op!=4 or cnt==0)-> RESP; IDLE -(accept op 4, cnt!=0)-> RUN;
//       RUN: each cycle acc <= acc + sum_{l=0..3} f[l]*(x[l]+input_offset); idx <= idx+1 mod DEPTH; cnt--;
//            on last word (cnt==1) -> RESP with outputs_0 = updated acc; RESP -(rsp_ready)-> IDLE.
//  Latency: non-run ops: rsp_valid 1 cycle after accept; RUN: LEN+1 cycles after accept (LEN=0: 1 cycle).
//  Arithmetic: lanes are bytes [7:0]..[31:24], signed int8; x+offset is signed 10b; products signed 18b;
//   4-lane sum signed 20b sign-extended; acc wraps modulo 2^32 (no saturation).
//  Index wraps modulo DEPTH (start 14, LEN 4 reads 14,15,0,1); LEN > DEPTH re-reads words cyclically.
//  Buffer reads combinational from register arrays; writes only in IDLE via opcodes 2/3.
//  Reset mid-RUN/RESP: immediate abort, FSM to IDLE, acc=0, no response emitted.
//  rsp_ready low: RESP holds rsp_valid=1 and stable outputs_0 indefinitely.
// CONFIGURATION
//  KWS_MACC_SEQ_PERF_EN defined: 32-bit perf counter increments every cycle in RUN, wraps at 2^32,
//   cleared by reset and by SET_ACC; readable via opcode 6.
//  Not defined: no counter logic; opcode 6 returns 0.
// STRUCTURE
//  Package kws_macc_pkg: function-ID localparams (OP_SET_OFF..OP_RSVD), FSM state enum {IDLE,RUN,RESP},
//   lane width (8), offset width (9), acc width (32).
//  Sub-module simd_macc4: combinational 4-lane dot product (filt word, input word, offset) -> signed 20b sum.
//  Top holds FSM, buffers, counters, acc register, response register.
// TESTING
//  1 Reset released: cmd_ready=1, rsp_valid=0; RD_ACC -> 0 next cycle.
//  2 SET_OFF 0, SET_ACC 0, fill filt[0..3]=0x02020202, in[0..3]=0x03030303, RUN(0,4) -> rsp_valid 5 cycles after accept, result 96.
//  3 SET_OFF 128, filt[0]=0x01010101, in[0]=0x80808080, SET_ACC 7, RUN(0,1) -> result 7.
//  4 DEPTH 16: filt[14,15,0,1]=0x00000001, in same=0x00000005, others 0, off 0, acc 0, RUN(14,4) -> 20; RUN(3,0) -> 20 after 1 cycle.
//  5 RUN response with rsp_ready low 3 cycles: rsp_valid/outputs stable, cmd_ready=0; cmd_valid ignored until handshake.
//  6 Assert reset 2 cycles into RUN(0,8): next cycle state IDLE, rsp_valid=0, RD_ACC -> 0; with PERF_EN, RUN(0,4) then RD_PERF -> 4.

Source files
------------

// File: rtl/kws_macc_pkg.sv
// Shared definitions for the KWS MAC sequencer: widths, CFU function IDs,
// FSM states and the command payload layout.
package kws_macc_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned OFF_W  = 9;
  localparam int unsigned PROD_W = 18;
  localparam int unsigned SUM_W  = 20;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned FID_W  = 3;

  localparam logic [FID_W-1:0] OP_SET_OFF = 3'd0;
  localparam logic [FID_W-1:0] OP_SET_ACC = 3'd1;
  localparam logic [FID_W-1:0] OP_WR_FILT = 3'd2;
  localparam logic [FID_W-1:0] OP_WR_IN   = 3'd3;
  localparam logic [FID_W-1:0] OP_RUN     = 3'd4;
  localparam logic [FID_W-1:0] OP_RD_ACC  = 3'd5;
  localparam logic [FID_W-1:0] OP_RD_PERF = 3'd6;
  localparam logic [FID_W-1:0] OP_RSVD    = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [FID_W-1:0] fid;
    logic [ACC_W-1:0] in0;
    logic [ACC_W-1:0] in1;
  } cmd_t;

endpackage

// File: rtl/simd_macc4.sv
// Combinational 4-lane int8 dot product: sum_l f[l] * (x[l] + offset).
// Ports:
//   filt_word  in  32  four signed int8 filter lanes, lane 0 in [7:0]
//   in_word    in  32  four signed int8 input lanes, lane 0 in [7:0]
//   offset     in  9   signed input offset added to every input lane
//   sum_c      out 20  signed lane sum (combinational)
module simd_macc4
  import kws_macc_pkg::*;
(
  input  logic        [ACC_W-1:0] filt_word,
  input  logic        [ACC_W-1:0] in_word,
  input  logic signed [OFF_W-1:0] offset,
  output logic signed [SUM_W-1:0] sum_c
);

  logic [PROD_W-1:0] prod [LANES];

  // Per-lane product; operands are sign-extended to the product width so the
  // truncated unsigned multiply equals the signed product.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [LANE_W-1:0] f;
    logic [LANE_W-1:0] x;
    logic [OFF_W:0]    xo;
    assign f  = filt_word[l*LANE_W +: LANE_W];
    assign x  = in_word[l*LANE_W +: LANE_W];
    assign xo = {{(OFF_W+1-LANE_W){x[LANE_W-1]}}, x} + {offset[OFF_W-1], offset};
    assign prod[l] = {{(PROD_W-LANE_W){f[LANE_W-1]}}, f} *
                     {{(PROD_W-OFF_W-1){xo[OFF_W]}}, xo};
  end

  // Sign-extended accumulation of the four lane products.
  always_comb begin
    sum_c = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_c = sum_c + {{(SUM_W-PROD_W){prod[l][PROD_W-1]}}, prod[l]};
    end
  end

endmodule

// File: rtl/kws_macc_sequencer.sv
// CFU-attached sequencer that streams buffered filter/input words through a
// 4-lane int8 MAC into a 32-bit accumulator, one word per cycle.
// Optional feature macro: KWS_MACC_SEQ_PERF_EN adds a RUN-cycle counter
// readable via RD_PERF (returns 0 when not defined).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_valid / cmd_ready      command handshake (ready only in IDLE)
//   cmd_payload_function_id    3-bit opcode
//   cmd_payload_inputs_0/1     32-bit operands
//   rsp_valid / rsp_ready      response handshake (valid only in RESP)
//   rsp_payload_response_ok    constant 1
//   rsp_payload_outputs_0      registered 32-bit result
module kws_macc_sequencer
  import kws_macc_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [FID_W-1:0]  cmd_payload_function_id,
  input  logic [ACC_W-1:0]  cmd_payload_inputs_0,
  input  logic [ACC_W-1:0]  cmd_payload_inputs_1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_payload_response_ok,
  output logic [ACC_W-1:0]  rsp_payload_outputs_0
);

  state_e                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic signed [OFF_W-1:0] off_q, off_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ACC_W-1:0]        out_q, out_d;
  logic [ACC_W-1:0]        filt_q [DEPTH];
  logic [ACC_W-1:0]        in_q   [DEPTH];

  cmd_t                    cmd_c;
  logic                    accept_c;
  logic                    filt_we_c;
  logic                    in_we_c;
  logic signed [SUM_W-1:0] sum_c;
  logic [ACC_W-1:0]        sum_ext_c;
  logic [ACC_W-1:0]        perf_c;

  assign cmd_c    = {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1};
  assign accept_c = cmd_valid && (state_q == IDLE);

  assign cmd_ready               = (state_q == IDLE);
  assign rsp_valid               = (state_q == RESP);
  assign rsp_payload_response_ok = 1'b1;
  assign rsp_payload_outputs_0   = out_q;

  simd_macc4 u_macc (
    .filt_word (filt_q[idx_q]),
    .in_word   (in_q[idx_q]),
    .offset    (off_q),
    .sum_c     (sum_c)
  );

  assign sum_ext_c = {{(ACC_W-SUM_W){sum_c[SUM_W-1]}}, sum_c};

  // Next-state, datapath and response selection.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    off_d     = off_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    filt_we_c = 1'b0;
    in_we_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = RESP;
          out_d   = '0;
          unique case (cmd_c.fid)
            OP_SET_OFF: off_d = cmd_c.in0[OFF_W-1:0];
            OP_SET_ACC: begin
              acc_d = cmd_c.in0;
              out_d = cmd_c.in0;
            end
            OP_WR_FILT: filt_we_c = 1'b1;
            OP_WR_IN:   in_we_c   = 1'b1;
            OP_RUN: begin
              idx_d = cmd_c.in0[ADDR_W-1:0];
              cnt_d = cmd_c.in1[CNT_W-1:0];
              // Zero-length run answers immediately with the current acc.
              if (cmd_c.in1[CNT_W-1:0] != '0) state_d = RUN;
              else                            out_d   = acc_q;
            end
            OP_RD_ACC:  out_d = acc_q;
            OP_RD_PERF: out_d = perf_c;
            default:    out_d = '0;
          endcase
        end
      end
      RUN: begin
        acc_d = acc_q + sum_ext_c;
        idx_d = idx_q + ADDR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          out_d   = acc_d;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control/datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      off_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      off_q   <= off_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Word buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    if (filt_we_c) filt_q[cmd_c.in0[ADDR_W-1:0]] <= cmd_c.in1;
    if (in_we_c)   in_q[cmd_c.in0[ADDR_W-1:0]]   <= cmd_c.in1;
  end

`ifdef KWS_MACC_SEQ_PERF_EN
  logic [ACC_W-1:0] perf_q, perf_d;

  // Counts cycles spent streaming; SET_ACC restarts the measurement.
  always_comb begin
    perf_d = perf_q;
    if (state_q == RUN)                             perf_d = perf_q + ACC_W'(1);
    else if (accept_c && cmd_c.fid == OP_SET_ACC)   perf_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_c = perf_q;
`else
  logic unused_accept;
  assign unused_accept = accept_c;
  assign perf_c        = '0;
`endif

endmodule

// File: tb/tb_kws_macc_sequencer.sv
// Self-checking bench for kws_macc_sequencer: a transaction-level model
// predicts handshake timing and results, checked every cycle, plus directed
// scenarios with hand-computed literal results and a randomized phase.
module tb_kws_macc_sequencer;
  import kws_macc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  fid;
  logic [31:0] in0, in1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_ok;
  logic [31:0] rsp_out;

  int n_chk  = 0;
  int n_fail = 0;

  kws_macc_sequencer dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_response_ok (rsp_ok),
    .rsp_payload_outputs_0   (rsp_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mf [16];
  logic [31:0] mx [16];
  logic [31:0] m_acc  = '0;
  logic [31:0] m_perf = '0;
  logic [31:0] m_res  = '0;
  int          m_off  = 0;
  bit          m_busy = 1'b0;
  int          m_resp_cyc = 0;
  int          cyc = 0;
  bit          model_on = 1'b0;

  function automatic logic [31:0] dot(input logic [31:0] f, input logic [31:0] x, input int off);
    int s;
    int fl;
    int xl;
    s = 0;
    for (int l = 0; l < 4; l++) begin
      fl = int'($signed(f[l*8 +: 8]));
      xl = int'($signed(x[l*8 +: 8]));
      s += fl * (xl + off);
    end
    return 32'(s);
  endfunction

  // Model advances on each clock edge from the same inputs the DUT sees.
  always @(posedge clk) begin
    int len;
    int lat;
    cyc++;
    if (reset) begin
      m_busy = 1'b0; m_acc = '0; m_off = 0; m_res = '0; m_perf = '0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        lat   = 1;
        m_res = '0;
        case (fid)
          OP_SET_OFF: m_off = int'($signed(in0[8:0]));
          OP_SET_ACC: begin m_acc = in0; m_res = in0; m_perf = '0; end
          OP_WR_FILT: mf[in0[3:0]] = in1;
          OP_WR_IN:   mx[in0[3:0]] = in1;
          OP_RUN: begin
            len = int'(in1[15:0]);
            for (int k = 0; k < len; k++)
              m_acc = m_acc + dot(mf[(int'(in0[3:0]) + k) % 16], mx[(int'(in0[3:0]) + k) % 16], m_off);
            m_perf = m_perf + 32'(len);
            m_res  = m_acc;
            if (len != 0) lat = len + 1;
          end
          OP_RD_ACC:  m_res = m_acc;
`ifdef KWS_MACC_SEQ_PERF_EN
          OP_RD_PERF: m_res = m_perf;
`endif
          default:    m_res = '0;
        endcase
        m_busy     = 1'b1;
        m_resp_cyc = cyc + lat - 1;
      end
    end else if (cyc > m_resp_cyc && rsp_ready) begin
      m_busy = 1'b0;
    end
  end

  // Every-cycle comparison of handshake and result against the model.
  always @(negedge clk) begin
    bit exp_v;
    if (model_on && !reset) begin
      exp_v = m_busy && (cyc >= m_resp_cyc);
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      chk("response_ok", 32'(rsp_ok), 32'd1);
      if (exp_v) chk("outputs_0", rsp_out, m_res);
    end
  end

  // ---------------- driver ----------------
  task automatic drive_junk(input bit junk);
    if (junk) begin
      cmd_valid = 1'($urandom);
      fid       = 3'($urandom);
      in0       = $urandom;
      in1       = $urandom;
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit junk,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    cmd_valid = 1'b1; fid = f; in0 = a; in1 = b; rsp_ready = 1'b0;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      drive_junk(junk);
    end while (!rsp_valid && lat < 64);
    if (!rsp_valid) begin
      n_chk++; n_fail++;
      $display("FAIL response_timeout: got no rsp_valid required within 64 cycles, op %0d", f);
    end
    res = rsp_out;
    repeat (hold) begin
      @(negedge clk);
      drive_junk(junk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got %0d cycles", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    int          lat;
    reset = 1'b0; cmd_valid = 1'b0; fid = '0; in0 = '0; in1 = '0; rsp_ready = 1'b0;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_on = 1'b1;

    // 1: reset state
    #1;
    chk("t1_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t1_outputs_0", rsp_out, 32'd0);
    issue(OP_RD_ACC, 0, 0, 0, 1'b0, r, lat);
    chk("t1_rd_acc", r, 32'd0);
    chk("t1_latency", 32'(lat), 32'd1);

    // 2: basic 4-word run
    issue(OP_SET_OFF, 0, 0, 0, 1'b0, r, lat);
    issue(OP_SET_ACC, 0, 0, 0, 1'b0, r, lat);
    for (int i = 0; i < 4; i++) begin
      issue(OP_WR_FILT, 32'(i), 32'h0202_0202, 0, 1'b0, r, lat);
      issue(OP_WR_IN,   32'(i), 32'h0303_0303, 0, 1'b0, r, lat);
    end
    issue(OP_RUN, 0, 4, 0, 1'b0, r, lat);
    chk("t2_run_result", r, 32'd96);
    chk("t2_run_latency", 32'(lat), 32'd5);
    issue(OP_SET_ACC, 32'hFFFF_FFF0, 0, 0, 1'b0, r, lat);
    chk("t2_set_acc_echo", r, 32'hFFFF_FFF0);
    issue(OP_RUN, 0, 4, 0, 1'b0, r, lat);
    chk("t2_acc_wrap", r, 32'h0000_0050);

    // 3: offset cancels -128 inputs
    issue(OP_SET_OFF, 128, 0, 0, 1'b0, r, lat);
    issue(OP_WR_FILT, 0, 32'h0101_0101, 0, 1'b0, r, lat);
    issue(OP_WR_IN,   0, 32'h8080_8080, 0, 1'b0, r, lat);
    issue(OP_SET_ACC, 7, 0, 0, 1'b0, r, lat);
    issue(OP_RUN, 0, 1, 0, 1'b0, r, lat);
    chk("t3_offset_run", r, 32'd7);
    chk("t3_latency", 32'(lat), 32'd2);

    // 4: index wrap and zero-length run
    for (int i = 0; i < 16; i++) begin
      bit sel;
      sel = (i == 14) || (i == 15) || (i == 0) || (i == 1);
      issue(OP_WR_FILT, 32'(i), sel ? 32'd1 : 32'd0, 0, 1'b0, r, lat);
      issue(OP_WR_IN,   32'(i), sel ? 32'd5 : 32'd0, 0, 1'b0, r, lat);
    end
    issue(OP_SET_OFF, 0, 0, 0, 1'b0, r, lat);
    issue(OP_SET_ACC, 0, 0, 0, 1'b0, r, lat);
    issue(OP_RUN, 14, 4, 0, 1'b0, r, lat);
    chk("t4_wrap_run", r, 32'd20);
    issue(OP_RUN, 3, 0, 0, 1'b0, r, lat);
    chk("t4_len0_result", r, 32'd20);
    chk("t4_len0_latency", 32'(lat), 32'd1);
    issue(OP_RSVD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, r, lat);
    chk("t4_reserved", r, 32'd0);

    // 5: back-pressured response with junk commands offered meanwhile
    issue(OP_RUN, 14, 2, 3, 1'b1, r, lat);
    chk("t5_held_result", r, 32'd30);
    issue(OP_RD_ACC, 0, 0, 0, 1'b0, r, lat);
    chk("t5_acc_after", r, 32'd30);

    // 6: reset in the middle of a run
    @(negedge clk);
    cmd_valid = 1'b1; fid = OP_RUN; in0 = 0; in1 = 8;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t6_outputs_0", rsp_out, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    issue(OP_RD_ACC, 0, 0, 0, 1'b0, r, lat);
    chk("t6_rd_acc", r, 32'd0);
    issue(OP_RUN, 0, 4, 0, 1'b0, r, lat);
    chk("t6_run_after_reset", r, 32'd10);
    issue(OP_RD_PERF, 0, 0, 0, 1'b0, r, lat);
`ifdef KWS_MACC_SEQ_PERF_EN
    chk("t6_rd_perf", r, 32'd4);
`else
    chk("t6_rd_perf", r, 32'd0);
`endif

    // Randomized commands checked by the model
    for (int i = 0; i < 16; i++) begin
      issue(OP_WR_FILT, 32'(i), $urandom, 0, 1'b0, r, lat);
      issue(OP_WR_IN,   32'(i), $urandom, 0, 1'b0, r, lat);
    end
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  op;
      logic [31:0] b;
      op = 3'($urandom_range(0, 7));
      b  = (op == OP_RUN) ? 32'($urandom_range(0, 20)) | ($urandom & 32'hFFFF_0000) : $urandom;
      issue(op, $urandom, b, $urandom_range(0, 3), 1'($urandom), r, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
